// File: rtl/seven_seg_scroller.sv
// seven_seg_scroller
//   Holds a short message of 5-bit character codes, encodes each one into an
//   abcdefgh segment pattern and scrolls the message right-to-left across
//   N_DIGITS display positions. The window is one registered byte per digit;
//   a downstream multiplexer only selects and drives the digits.
//
// Ports
//   clock      system clock
//   reset      synchronous, active-high; clears buffer to blank, FSM to IDLE
//   wr_en      write wr_char into buffer[wr_addr] (allowed in any state)
//   wr_addr    buffer write index
//   wr_char    character code (0-9, A b C d E F G H L P U -, 22-31 blank)
//   msg_len    message length, latched on start (clamped to MSG_DEPTH)
//   start      pulse: begin/restart scrolling (msg_len==0 returns to IDLE)
//   pause      level: freeze timer and position while high
//   busy       high while running or paused
//   step       1-cycle pulse in the cycle the position advances
//   wrap       1-cycle pulse when the position returns to 0
//   digit_seg  digit k pattern at [8k+7:8k], bit7=a .. bit0=h(dp, always 0)

module seven_seg_scroller #(
    parameter int N_DIGITS    = 4,
    parameter int MSG_DEPTH   = 16,
    parameter int STEP_CYCLES = 13_500_000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [4:0]                   wr_char,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         pause,
    output logic                         busy,
    output logic                         step,
    output logic                         wrap,
    output logic [8*N_DIGITS-1:0]        digit_seg
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    // pos spans 0 .. MSG_DEPTH+N_DIGITS-1
    localparam int PW = $clog2(MSG_DEPTH + N_DIGITS);
    // window index reaches pos + N_DIGITS-1, so leave room for that overshoot
    localparam int IW = $clog2(MSG_DEPTH + 2 * N_DIGITS);
    localparam int TW = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          step_nxt, wrap_nxt;
    logic [4:0]    buffer [MSG_DEPTH];
    logic [8*N_DIGITS-1:0] seg_nxt;
    logic [PW-1:0] last_pos;

    function automatic logic [7:0] encode(input logic [4:0] ch);
        case (ch)
            5'd0:  encode = 8'hFC;
            5'd1:  encode = 8'h60;
            5'd2:  encode = 8'hDA;
            5'd3:  encode = 8'hF2;
            5'd4:  encode = 8'h66;
            5'd5:  encode = 8'hB6;
            5'd6:  encode = 8'hBE;
            5'd7:  encode = 8'hE0;
            5'd8:  encode = 8'hFE;
            5'd9:  encode = 8'hF6;
            5'd10: encode = 8'hEE;
            5'd11: encode = 8'h3E;
            5'd12: encode = 8'h9C;
            5'd13: encode = 8'h7A;
            5'd14: encode = 8'h9E;
            5'd15: encode = 8'h8E;
            5'd16: encode = 8'hBC;
            5'd17: encode = 8'h6E;
            5'd18: encode = 8'h1C;
            5'd19: encode = 8'hCE;
            5'd20: encode = 8'h7C;
            5'd21: encode = 8'h02;
            default: encode = 8'h00;
        endcase
    endfunction

    assign busy     = (state != IDLE);
    // last position of the virtual sequence: message then N_DIGITS blanks
    assign last_pos = PW'(len) + PW'(N_DIGITS - 1);

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        pos_nxt   = pos;
        timer_nxt = timer;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (start) begin
            // start wins over pause for this cycle
            pos_nxt   = '0;
            timer_nxt = '0;
            if (msg_len == '0) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = RUN;
                len_nxt   = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
            end
        end else if (state != IDLE) begin
            state_nxt = pause ? PAUSED : RUN;
            if (!pause) begin
                if (timer == TW'(STEP_CYCLES - 1)) begin
                    timer_nxt = '0;
                    step_nxt  = 1'b1;
                    if (pos == last_pos) begin
                        pos_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
        end
    end

    // Window from the current pos/buffer; registered so it lags pos by one edge.
    always_comb begin
        logic [IW-1:0] idx;
        logic [4:0]    ch;
        seg_nxt = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            idx = IW'(pos) + IW'(N_DIGITS - 1 - k);
            ch  = (idx < IW'(len)) ? buffer[idx[AW-1:0]] : 5'd31;
            if (state != IDLE)
                seg_nxt[8*k +: 8] = encode(ch);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            pos       <= '0;
            timer     <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            digit_seg <= '0;
            for (int i = 0; i < MSG_DEPTH; i++)
                buffer[i] <= 5'd31;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            pos       <= pos_nxt;
            timer     <= timer_nxt;
            step      <= step_nxt;
            wrap      <= wrap_nxt;
            digit_seg <= seg_nxt;
            if (wr_en)
                buffer[wr_addr] <= wr_char;
        end
    end

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Bench for seven_seg_scroller: directed vectors, a tick-count reference model
// compared every cycle, and literal expectations at key points.

module tb_seven_seg_scroller;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int SC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [4:0]  wr_char = '0;
    logic [4:0]  msg_len = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        busy, step, wrap;
    logic [31:0] digit_seg;

    int total = 0;
    int bad   = 0;

    seven_seg_scroller #(.N_DIGITS(N), .MSG_DEPTH(D), .STEP_CYCLES(SC)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .msg_len(msg_len), .start(start), .pause(pause),
        .busy(busy), .step(step), .wrap(wrap), .digit_seg(digit_seg)
    );

    always #5 clock = ~clock;

    // Model: position is just (active ticks since start / SC) mod (L+N).
    logic [4:0]  m_buf [D];
    bit          m_run = 0;
    int          m_len = 0;
    int          m_ticks = 0;
    logic [31:0] e_seg = '0;
    bit          e_step = 0, e_wrap = 0, e_busy = 0;
    bit          chk_en = 0;

    function automatic logic [7:0] pat(input logic [4:0] c);
        case (c)
            0: pat = 8'hFC;  1: pat = 8'h60;  2: pat = 8'hDA;  3: pat = 8'hF2;
            4: pat = 8'h66;  5: pat = 8'hB6;  6: pat = 8'hBE;  7: pat = 8'hE0;
            8: pat = 8'hFE;  9: pat = 8'hF6;  10: pat = 8'hEE; 11: pat = 8'h3E;
            12: pat = 8'h9C; 13: pat = 8'h7A; 14: pat = 8'h9E; 15: pat = 8'h8E;
            16: pat = 8'hBC; 17: pat = 8'h6E; 18: pat = 8'h1C; 19: pat = 8'hCE;
            20: pat = 8'h7C; 21: pat = 8'h02;
            default: pat = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] win(input int p);
        logic [31:0] w;
        int idx;
        w = '0;
        for (int k = 0; k < N; k++) begin
            idx = p + N - 1 - k;
            w[8*k +: 8] = pat((idx < m_len) ? m_buf[idx] : 5'd31);
        end
        return w;
    endfunction

    always @(posedge clock) begin
        e_seg  = m_run ? win((m_ticks / SC) % (m_len + N)) : 32'h0;
        e_step = 0;
        e_wrap = 0;
        if (reset) begin
            for (int i = 0; i < D; i++) m_buf[i] = 5'd31;
            m_run = 0; m_len = 0; m_ticks = 0; e_seg = '0;
        end else begin
            if (wr_en) m_buf[wr_addr] = wr_char;
            if (start) begin
                m_run   = (msg_len != 0);
                m_len   = (msg_len > D) ? D : int'(msg_len);
                m_ticks = 0;
            end else if (m_run && !pause) begin
                m_ticks++;
                if (m_ticks % SC == 0) begin
                    e_step = 1;
                    e_wrap = ((m_ticks / SC) % (m_len + N)) == 0;
                end
            end
        end
        e_busy = m_run;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("seg",  digit_seg, e_seg);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("step", 32'(step), 32'(e_step));
            chk("wrap", 32'(wrap), 32'(e_wrap));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input int c);
        wr_en = 1; wr_addr = 4'(a); wr_char = 5'(c);
        tick();
        wr_en = 0;
    endtask

    task automatic go(input int len);
        msg_len = 5'(len); start = 1;
        tick();
        start = 0;
    endtask

    // Counts step pulses until a wrap pulse, bounded.
    task automatic wait_wrap(output int steps, output bit ok);
        steps = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (step) steps++;
            if (wrap) begin ok = 1; break; end
        end
    endtask

    int  nsteps;
    bit  ok;

    initial begin
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        repeat (20) tick();
        chk("idle_seg", digit_seg, 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        wr(0, 15); wr(1, 19); wr(2, 16); wr(3, 10);
        go(4);
        tick();
        chk("win0", digit_seg, 32'h8ECEBCEE);
        repeat (4) tick();
        chk("win1", digit_seg, 32'hCEBCEE00);
        wait_wrap(nsteps, ok);
        chk("wrap_seen", 32'(ok), 32'h1);
        chk("wrap_step", 32'(step), 32'h1);
        chk("steps_to_wrap4", 32'(nsteps), 32'd7);

        // pause mid-step, then resume
        repeat (6) tick();
        pause = 1;
        repeat (10) tick();
        pause = 0;
        repeat (12) tick();

        // live edit of a displayed character
        msg_len = 4; start = 1;
        tick();
        start = 0;
        wr_en = 1; wr_addr = 1; wr_char = 8;
        tick();
        wr_en = 0;
        tick();
        chk("live_edit", digit_seg, 32'h8EFEBCEE);

        // length clamps to the buffer depth
        go(20);
        wait_wrap(nsteps, ok);
        chk("wrap_seen20", 32'(ok), 32'h1);
        chk("steps_to_wrap20", 32'(nsteps), 32'd20);

        go(0);
        chk("len0_busy", 32'(busy), 32'h0);
        tick();
        chk("len0_seg", digit_seg, 32'h0);

        // simultaneous start and write
        wr_en = 1; wr_addr = 0; wr_char = 1; msg_len = 1; start = 1;
        tick();
        wr_en = 0; start = 0;
        tick();
        chk("start_wr", digit_seg, 32'h60000000);

        // reset at pos 3
        go(4);
        repeat (12) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_seg", digit_seg, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        go(4);
        tick();
        chk("rst_blank", digit_seg, 32'h0);
        chk("rst_busy2", 32'(busy), 32'h1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
